// File: rtl/beeper_seq_core.sv
// beeper_seq_core: NCO square-wave beeper with OFF/ON/TIME/FORCE_ZERO/FORCE_ONE modes and
// a SEQ mode that plays {phase, ticks} notes back-to-back from an internal FIFO.
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   mode_i             0 OFF, 1 ON, 2 TIME, 3 FORCE_ZERO, 4 FORCE_ONE, 5 SEQ, 6/7 behave as OFF
//   phase_i            NCO phase, loaded by phase_wr_stb_i (used from the next cycle)
//   gen_time_i         TIME-mode duration in clocks, loaded by timer_run_stb_i
//   note_*             note push interface (phase 0 = rest); note_ready_o = queue not full
//   seq_start_stb_i    start playback in SEQ mode
//   seq_abort_stb_i    stop playback and flush the queue
//   beep_o, busy_o     registered tone output and activity flag
//   q_level_o          number of queued notes
//   seq_done_irq_o     one-clock pulse when playback ends by queue exhaustion
//                      (present only when BEEPER_SEQ_IRQ_EN is defined)

module beeper_seq_core #(
    parameter int unsigned CLK_FREQ     = 62_500_000,
    parameter int unsigned DEFAULT_FREQ = 1000,
    parameter int unsigned PHASE_W      = 32,
    parameter int unsigned TICKS_W      = 32,
    parameter int unsigned QUEUE_DEPTH  = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [2:0]                   mode_i,
    input  logic [PHASE_W-1:0]           phase_i,
    input  logic                         phase_wr_stb_i,
    input  logic [TICKS_W-1:0]           gen_time_i,
    input  logic                         timer_run_stb_i,
    input  logic                         note_valid_i,
    output logic                         note_ready_o,
    input  logic [PHASE_W-1:0]           note_phase_i,
    input  logic [TICKS_W-1:0]           note_ticks_i,
    input  logic                         seq_start_stb_i,
    input  logic                         seq_abort_stb_i,
`ifdef BEEPER_SEQ_IRQ_EN
    output logic                         seq_done_irq_o,
`endif
    output logic                         beep_o,
    output logic                         busy_o,
    output logic [$clog2(QUEUE_DEPTH):0] q_level_o
);

    localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
    localparam int unsigned LvlW = PtrW + 1;
    localparam logic [PHASE_W-1:0] PhaseRst =
        PHASE_W'(((64'd1 << PHASE_W) * 64'(DEFAULT_FREQ)) / 64'(CLK_FREQ));
    localparam logic [LvlW-1:0] LvlFull = LvlW'(QUEUE_DEPTH);

    localparam logic [2:0] ModeOn     = 3'd1;
    localparam logic [2:0] ModeTime   = 3'd2;
    localparam logic [2:0] ModeForce0 = 3'd3;
    localparam logic [2:0] ModeForce1 = 3'd4;
    localparam logic [2:0] ModeSeq    = 3'd5;

    typedef enum logic {StIdle, StPlay} state_e;

    state_e               state_q, state_d;
    logic [PHASE_W-1:0]   acc_q, acc_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [TICKS_W-1:0]   timer_q, timer_d;
    logic [TICKS_W-1:0]   cnt_q, cnt_d;
    logic [PHASE_W-1:0]   cur_phase_q, cur_phase_d;
    logic                 beep_q, beep_d;
    logic                 busy_q, busy_d;
    logic                 mode_seq_q;
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0]      level_q, level_d;
    logic [PHASE_W-1:0]   mem_phase_q [QUEUE_DEPTH];
    logic [TICKS_W-1:0]   mem_ticks_q [QUEUE_DEPTH];

    logic                 is_seq, flush, full, empty, push, pop, seq_done;
    logic                 time_gen, seq_gen, gen;
    logic [PHASE_W-1:0]   active_phase, acc_sum;
    logic [PHASE_W-1:0]   head_phase;
    logic [TICKS_W-1:0]   head_ticks;

    // Queue status and push qualification
    always_comb begin
        is_seq     = (mode_i == ModeSeq);
        // Leaving SEQ flushes, so a queue filled in SEQ never survives into another mode
        flush      = seq_abort_stb_i | (mode_seq_q & ~is_seq);
        full       = (level_q == LvlFull);
        empty      = (level_q == '0);
        head_phase = mem_phase_q[rd_ptr_q];
        head_ticks = mem_ticks_q[rd_ptr_q];
        // Full-check uses the pre-pop level: a push at full is dropped even with a pop
        push       = note_valid_i & ~full & ~flush;
    end

    // Sequencer next state
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cur_phase_d = cur_phase_q;
        pop         = 1'b0;
        seq_done    = 1'b0;
        if (flush || !is_seq) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (seq_start_stb_i && !empty) begin
                        pop         = 1'b1;
                        state_d     = StPlay;
                        cnt_d       = head_ticks;
                        cur_phase_d = head_phase;
                    end
                end
                StPlay: begin
                    cnt_d = cnt_q - TICKS_W'(1);
                    // cnt==0 only arises from a ticks=0 note, which lasts one clock
                    if (cnt_q <= TICKS_W'(1)) begin
                        if (!empty) begin
                            pop         = 1'b1;
                            cnt_d       = head_ticks;
                            cur_phase_d = head_phase;
                        end else begin
                            state_d  = StIdle;
                            seq_done = 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Timer, NCO and registered outputs
    always_comb begin
        timer_d = '0;
        if (mode_i == ModeTime) begin
            if (timer_run_stb_i) begin
                timer_d = gen_time_i;
            end else if (timer_q != '0) begin
                timer_d = timer_q - TICKS_W'(1);
            end
        end

        time_gen     = (mode_i == ModeTime) && (timer_q != '0);
        seq_gen      = is_seq && (state_q == StPlay) && !flush;
        gen          = (mode_i == ModeOn) | time_gen | seq_gen;
        active_phase = seq_gen ? cur_phase_q : phase_q;
        acc_sum      = acc_q + active_phase;
        // Accumulator clears whenever idle so every tone starts at phase 0
        acc_d        = (gen && !seq_done) ? acc_sum : '0;

        unique case (mode_i)
            ModeForce0: beep_d = 1'b0;
            ModeForce1: beep_d = 1'b1;
            // A rest note holds the line low regardless of accumulator contents
            default:    beep_d = gen & acc_sum[PHASE_W-1] & ~(seq_gen & (cur_phase_q == '0));
        endcase

        busy_d  = time_gen | seq_gen;
        phase_d = phase_wr_stb_i ? phase_i : phase_q;
        level_d = level_q + LvlW'(push) - LvlW'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            phase_q     <= PhaseRst;
            timer_q     <= '0;
            cnt_q       <= '0;
            cur_phase_q <= '0;
            beep_q      <= 1'b0;
            busy_q      <= 1'b0;
            mode_seq_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            phase_q     <= phase_d;
            timer_q     <= timer_d;
            cnt_q       <= cnt_d;
            cur_phase_q <= cur_phase_d;
            beep_q      <= beep_d;
            busy_q      <= busy_d;
            mode_seq_q  <= is_seq;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                level_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
                level_q <= level_d;
            end
        end
    end

    // Note storage needs no reset; validity is tracked by the pointers
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_phase_q[wr_ptr_q] <= note_phase_i;
            mem_ticks_q[wr_ptr_q] <= note_ticks_i;
        end
    end

`ifdef BEEPER_SEQ_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= seq_done;
        end
    end

    assign seq_done_irq_o = irq_q;
`else
    logic unused_seq_done;
    assign unused_seq_done = seq_done;
`endif

    assign beep_o       = beep_q;
    assign busy_o       = busy_q;
    assign q_level_o    = level_q;
    assign note_ready_o = ~full;

endmodule

// File: tb/tb_beeper_seq_core.sv
// Bench for beeper_seq_core: directed stimulus, a behavioural model checked every cycle,
// plus hand-computed literal expectations.
module tb_beeper_seq_core;

    localparam int QD = 8;

    logic        clk = 1'b0;
    logic        rst, phase_wr, run_stb, note_valid, note_ready, start, abort, beep, busy, irq;
    logic [2:0]  mode;
    logic [31:0] phase, gen_time, note_phase, note_ticks;
    logic [3:0]  level;

    always #5 clk = ~clk;

    beeper_seq_core dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .mode_i          (mode),
        .phase_i         (phase),
        .phase_wr_stb_i  (phase_wr),
        .gen_time_i      (gen_time),
        .timer_run_stb_i (run_stb),
        .note_valid_i    (note_valid),
        .note_ready_o    (note_ready),
        .note_phase_i    (note_phase),
        .note_ticks_i    (note_ticks),
        .seq_start_stb_i (start),
        .seq_abort_stb_i (abort),
`ifdef BEEPER_SEQ_IRQ_EN
        .seq_done_irq_o  (irq),
`endif
        .beep_o          (beep),
        .busy_o          (busy),
        .q_level_o       (level)
    );

`ifndef BEEPER_SEQ_IRQ_EN
    assign irq = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit [31:0] ph;
        bit [31:0] tk;
    } note_t;

    bit [31:0] m_acc, m_phase, m_cur_phase;
    longint    m_timer, m_left;
    bit        m_play, m_prev_seq;
    note_t     m_q[$];
    bit        exp_beep, exp_busy, exp_irq;

    task automatic model_step();
        bit        is_seq, flush, gen, rest, push_ok, ended;
        bit [31:0] ph, sum;
        note_t     n;
        longint    def_phase;
        if (rst) begin
            def_phase = ((64'd1 << 32) * 64'd1000) / 64'd62500000;
            m_acc = 0; m_phase = 32'(def_phase); m_timer = 0; m_play = 0; m_left = 0;
            m_q.delete(); m_prev_seq = 0; exp_beep = 0; exp_busy = 0; exp_irq = 0;
            return;
        end
        is_seq = (mode == 3'd5);
        flush  = abort || (m_prev_seq && !is_seq);
        gen = 0; rest = 0; ph = m_phase;
        if (mode == 3'd1) gen = 1;
        else if (mode == 3'd2) gen = (m_timer != 0);
        else if (is_seq && m_play && !flush) begin
            gen = 1; ph = m_cur_phase; rest = (m_cur_phase == 0);
        end
        sum = m_acc + ph;
        exp_beep = (mode == 3'd4) ? 1'b1 : (mode == 3'd3) ? 1'b0 : (gen && !rest && sum[31]);
        exp_busy = gen && (mode != 3'd1);
        exp_irq  = 0;

        if (mode != 3'd2) m_timer = 0;
        else if (run_stb) m_timer = gen_time;
        else if (m_timer != 0) m_timer--;

        push_ok = note_valid && (m_q.size() < QD) && !flush;
        ended = 0;
        if (flush) begin
            m_q.delete(); m_play = 0;
        end else if (is_seq) begin
            if (m_play) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_q.size() != 0) begin
                        n = m_q.pop_front();
                        m_cur_phase = n.ph; m_left = (n.tk == 0) ? 1 : longint'(n.tk);
                    end else begin
                        m_play = 0; ended = 1; exp_irq = 1;
                    end
                end
            end else if (start && m_q.size() != 0) begin
                n = m_q.pop_front();
                m_cur_phase = n.ph; m_left = (n.tk == 0) ? 1 : longint'(n.tk);
                m_play = 1;
            end
        end
        if (push_ok) begin
            n.ph = note_phase; n.tk = note_ticks;
            m_q.push_back(n);
        end
        m_acc = (gen && !ended) ? sum : 32'd0;
        m_prev_seq = is_seq;
        if (phase_wr) m_phase = phase;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Every-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("beep", beep, exp_beep);
            check("busy", busy, exp_busy);
            check("level", level, m_q.size());
            check("ready", note_ready, (m_q.size() < QD));
`ifdef BEEPER_SEQ_IRQ_EN
            check("irq", irq, exp_irq);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_note(input bit [31:0] ph, input bit [31:0] tk);
        note_valid = 1; note_phase = ph; note_ticks = tk;
        tick();
        note_valid = 0;
    endtask

    initial begin
        int        rise_at, cnt, irq_cnt;
        bit [7:0]  pat8;
        bit [14:0] pat15;
        bit [2:0]  mlist [4];
        bit        blist [4];

        rst = 1; mode = 0; phase = 0; phase_wr = 0; gen_time = 0; run_stb = 0;
        note_valid = 0; note_phase = 0; note_ticks = 0; start = 0; abort = 0;
        tick();
        chk_en = 1;
        tick();
        rst = 0;
        check("rst_beep", beep, 0);
        check("rst_busy", busy, 0);
        check("rst_level", level, 0);
        check("rst_ready", note_ready, 1);

        // ON with reset phase 68719: MSB first set after 31251 clocks
        mode = 3'd1;
        rise_at = -1;
        for (int k = 1; k <= 40000; k++) begin
            tick();
            if (beep) begin
                rise_at = k;
                break;
            end
        end
        check("on_default_first_rise", rise_at, 31251);

        // Quarter-scale phase: period 4, rising 2 clocks after mode change
        mode = 3'd0; phase = 32'h4000_0000; phase_wr = 1;
        tick();
        phase_wr = 0; mode = 3'd1;
        pat8 = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            pat8 = {pat8[6:0], beep};
        end
        check("on_quarter_pattern", pat8, 8'b0110_0110);

        // TIME 10 clocks
        mode = 3'd2;
        tick();
        gen_time = 10; run_stb = 1;
        tick();
        run_stb = 0;
        cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            cnt += int'(busy);
        end
        check("time_busy_10", cnt, 10);
        check("time_end_beep", beep, 0);

        // Restrobe at clock 5 extends to 15
        run_stb = 1;
        tick();
        run_stb = 0;
        cnt = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            cnt += int'(busy);
            if (i == 4) run_stb = 1;
            if (i == 5) run_stb = 0;
        end
        check("time_restrobe_15", cnt, 15);

        // gen_time 0 gives no tone
        gen_time = 0; run_stb = 1;
        tick();
        run_stb = 0;
        tick();
        check("time_zero_busy", busy, 0);

        // SEQ three notes, gapless
        mode = 3'd5;
        push_note(32'h8000_0000, 4);
        push_note(32'h0000_0000, 3);
        push_note(32'h4000_0000, 8);
        check("seq_level3", level, 3);
        start = 1;
        tick();
        start = 0;
        check("seq_start_beep", beep, 0);
        pat15 = 0; cnt = 0; irq_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            pat15 = {pat15[13:0], beep};
            cnt += int'(busy);
            irq_cnt += int'(irq);
        end
        check("seq_pattern", pat15, 15'b101_0000_0110_0110);
        check("seq_busy_15", cnt, 15);
        tick();
        irq_cnt += int'(irq);
        check("seq_busy_after", busy, 0);
`ifdef BEEPER_SEQ_IRQ_EN
        check("seq_irq_once", irq_cnt, 1);
`endif

        // Overfill: 10 pushes, 8 kept
        note_valid = 1; note_phase = 32'h1000_0000; note_ticks = 5;
        for (int i = 0; i < 10; i++) tick();
        note_valid = 0;
        check("full_level", level, 8);
        check("full_ready", note_ready, 0);
        note_valid = 1; start = 1;
        tick();
        note_valid = 0; start = 0;
        check("full_push_start_level", level, 7);

        // Abort mid-play
        tick();
        tick();
        abort = 1;
        tick();
        abort = 0;
        check("abort_beep", beep, 0);
        check("abort_busy", busy, 0);
        check("abort_level", level, 0);
        check("abort_irq", irq, 0);

        // Mode -> OFF mid-play
        push_note(32'h2000_0000, 6);
        push_note(32'h2000_0000, 6);
        start = 1;
        tick();
        start = 0;
        tick();
        tick();
        mode = 3'd0;
        tick();
        check("off_busy", busy, 0);
        check("off_level", level, 0);
        check("off_irq", irq, 0);

        // Reset mid-play
        mode = 3'd5;
        push_note(32'h3000_0000, 7);
        push_note(32'h3000_0000, 7);
        start = 1;
        tick();
        start = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        check("midrst_beep", beep, 0);
        check("midrst_busy", busy, 0);
        check("midrst_level", level, 0);
        check("midrst_ready", note_ready, 1);

        // Force and unused modes
        mlist = '{3'd3, 3'd4, 3'd6, 3'd7};
        blist = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            mode = mlist[i];
            tick();
            check($sformatf("mode%0d_beep", mlist[i]), beep, blist[i]);
        end

        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
